digseg_scan_ctrl: RTL and testbench

//  Bus-attached, time-multiplexed hex display controller for NUM_DIGITS common-anode digits.
//  The CPU writes a packed nibble value and a control word. The block scans digits round-robin
//  at a programmable rate and drives one shared 7-bit segment bus plus per-digit anode enables.
//  It is the multi-digit successor of the single-digit combinational segment decoder and sits
//  on the same peripheral bus (ce/we/ack).

---
 rtl/digseg_scan_ctrl_pkg.sv | 32 +++
 rtl/digseg_hex2seg.sv | 32 +++
 rtl/digseg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_digseg_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/digseg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed hex display controller:
// bus widths, register map and the 7-segment glyph patterns {a,b,c,d,e,f,g}.
package digseg_scan_ctrl_pkg;

    localparam int DIGSEG_ADDR_W = 2;
    localparam int DIGSEG_DATA_W = 32;

    typedef enum logic [1:0] {
        REG_VALUE  = 2'd0,
        REG_CTRL   = 2'd1,
        REG_STATUS = 2'd2,
        REG_RSVD   = 2'd3
    } digseg_reg_e;

    localparam logic [6:0] SEG_HEX_0 = 7'h7E;
    localparam logic [6:0] SEG_HEX_1 = 7'h30;
    localparam logic [6:0] SEG_HEX_2 = 7'h6D;
    localparam logic [6:0] SEG_HEX_3 = 7'h79;
    localparam logic [6:0] SEG_HEX_4 = 7'h33;
    localparam logic [6:0] SEG_HEX_5 = 7'h5B;
    localparam logic [6:0] SEG_HEX_6 = 7'h5F;
    localparam logic [6:0] SEG_HEX_7 = 7'h70;
    localparam logic [6:0] SEG_HEX_8 = 7'h7F;
    localparam logic [6:0] SEG_HEX_9 = 7'h73;
    localparam logic [6:0] SEG_HEX_A = 7'h77;
    localparam logic [6:0] SEG_HEX_B = 7'h1F;
    localparam logic [6:0] SEG_HEX_C = 7'h4E;
    localparam logic [6:0] SEG_HEX_D = 7'h3D;
    localparam logic [6:0] SEG_HEX_E = 7'h4F;
    localparam logic [6:0] SEG_HEX_F = 7'h47;

endpackage

// File: rtl/digseg_hex2seg.sv
// Combinational hex nibble to 7-segment decoder, segments active-high.
module digseg_hex2seg
    import digseg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    // Glyph lookup for one nibble
    always_comb begin
        seg_o = SEG_HEX_0;
        case (hex_i)
            4'h0: seg_o = SEG_HEX_0;
            4'h1: seg_o = SEG_HEX_1;
            4'h2: seg_o = SEG_HEX_2;
            4'h3: seg_o = SEG_HEX_3;
            4'h4: seg_o = SEG_HEX_4;
            4'h5: seg_o = SEG_HEX_5;
            4'h6: seg_o = SEG_HEX_6;
            4'h7: seg_o = SEG_HEX_7;
            4'h8: seg_o = SEG_HEX_8;
            4'h9: seg_o = SEG_HEX_9;
            4'hA: seg_o = SEG_HEX_A;
            4'hB: seg_o = SEG_HEX_B;
            4'hC: seg_o = SEG_HEX_C;
            4'hD: seg_o = SEG_HEX_D;
            4'hE: seg_o = SEG_HEX_E;
            4'hF: seg_o = SEG_HEX_F;
        endcase
    end

endmodule

// File: rtl/digseg_scan_ctrl.sv
// Bus-attached multiplexed hex display controller for NUM_DIGITS common-anode
// digits. Registers: VALUE (packed nibbles, digit 0 rightmost), CTRL (bit0 EN),
// STATUS (current digit index). Optional build macro DIGSEG_LZB_EN enables
// leading-zero blanking of digits above digit 0.
module digseg_scan_ctrl
    import digseg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_i,
    input  logic                     we_i,
    input  logic [DIGSEG_ADDR_W-1:0] addr_i,
    input  logic [DIGSEG_DATA_W-1:0] data_i,
    output logic [DIGSEG_DATA_W-1:0] data_o,
    output logic                     ack_o,
    output logic [6:0]               seg_o,
    output logic [NUM_DIGITS-1:0]    an_o
);

    localparam int                VAL_W    = 4 * NUM_DIGITS;
    localparam int                PRE_W    = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [2:0]        IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [VAL_W-1:0]         value_q;
    logic                     en_q;
    logic [PRE_W-1:0]         pre_q;
    logic [2:0]               idx_q;
    logic                     ack_q;
    logic [DIGSEG_DATA_W-1:0] data_q;
    logic [6:0]               seg_q;
    logic [NUM_DIGITS-1:0]    an_q;

    logic                     accept;
    logic                     wr_value;
    logic                     wr_ctrl;
    logic                     en_d;
    logic                     tc;
    logic [DIGSEG_DATA_W-1:0] rd_data;
    logic [3:0]               nibble;
    logic                     blank;
    logic [6:0]               seg_dec;
    logic [NUM_DIGITS-1:0]    an_dec;
    logic                     unused_data;

    // Only the low VALUE bits and CTRL bit0 are stored; the rest of the bus is dropped
    assign unused_data = &{1'b0, data_i};

    digseg_hex2seg u_hex2seg (
        .hex_i (nibble),
        .seg_o (seg_dec)
    );

    // Bus decode, read mux, terminal count and current-digit selection
    always_comb begin
        accept   = ce_i & ~ack_q;
        wr_value = accept & we_i & (addr_i == REG_VALUE);
        wr_ctrl  = accept & we_i & (addr_i == REG_CTRL);
        en_d     = wr_ctrl ? data_i[0] : en_q;
        tc       = (pre_q == PRE_LAST);
        rd_data  = '0;
        case (addr_i)
            REG_VALUE:  rd_data = 32'(value_q);
            REG_CTRL:   rd_data = {31'b0, en_q};
            REG_STATUS: rd_data = {29'b0, idx_q};
            default:    rd_data = '0;
        endcase
        nibble = 4'(value_q >> {idx_q, 2'b00});
        an_dec = ~(NUM_DIGITS'(1) << idx_q);
        blank  = 1'b0;
`ifdef DIGSEG_LZB_EN
        // Blank a digit above 0 when it and every digit to its left are zero
        blank  = (idx_q != 3'd0) && ((value_q >> {idx_q, 2'b00}) == '0);
`endif
    end

    // Register file and bus handshake; a held ce_i is acked every other cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            ack_q <= accept;
            if (wr_value) value_q <= data_i[VAL_W-1:0];
            if (wr_ctrl)  en_q    <= data_i[0];
            if (accept && !we_i) data_q <= rd_data;
        end
    end

    // Dwell prescaler and digit index; counting starts the cycle after EN is set
    // and both are forced to zero on the edge that clears EN
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (!(en_q && en_d)) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (tc) begin
            pre_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Registered pin drive from the current index and VALUE
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q <= '0;
            an_q  <= '1;
        end else if (en_q) begin
            seg_q <= blank ? 7'b0 : seg_dec;
            an_q  <= an_dec;
        end else begin
            seg_q <= '0;
            an_q  <= '1;
        end
    end

    assign data_o = data_q;
    assign ack_o  = ack_q;
    assign seg_o  = seg_q;
    assign an_o   = an_q;

endmodule

// File: tb/tb_digseg_scan_ctrl.sv
// Scoreboard bench for digseg_scan_ctrl (NUM_DIGITS=4, CLK_DIV=4).
// Stimulus pushes expected bus responses and timestamped pin expectations;
// a negedge monitor pops and compares them.
module tb_digseg_scan_ctrl;

    typedef struct {
        int          stamp;
        int          kind;   // 0 pins {an,seg}, 1 ack_o, 2 data_o
        logic [31:0] exp;
        string       name;
    } tchk_t;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        string       name;
    } bchk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ack;
    logic [6:0]  seg;
    logic [3:0]  an;

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    late_cnt = 0;
    bit    finish_req = 0;
    tchk_t tq[$];
    bchk_t bq[$];
    tchk_t t_cur;
    bchk_t b_cur;
    logic [31:0] act;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    localparam logic [31:0] PINS_OFF = {21'b0, 4'hF, 7'h00};

    digseg_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .ce_i   (ce),
        .we_i   (we),
        .addr_i (addr),
        .data_i (wdata),
        .data_o (rdata),
        .ack_o  (ack),
        .seg_o  (seg),
        .an_o   (an)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int idx_after(input int k, input int e);
        return ((k - e) / 4) % 4;
    endfunction

    function automatic logic [31:0] pins_exp(input logic [15:0] v, input int idx);
        logic [3:0] an_e;
        logic [3:0] nib;
        logic [6:0] s;
        an_e = ~(4'b0001 << idx);
        nib  = v[4*idx +: 4];
        s    = seg_tab[nib];
`ifdef DIGSEG_LZB_EN
        if (idx != 0 && (v >> (4 * idx)) == 16'd0) s = 7'h00;
`endif
        return {21'b0, an_e, s};
    endfunction

    function automatic void push_t(input int stamp, input int kind, input logic [31:0] exp,
                                   input string name);
        tchk_t e;
        int pos;
        e.stamp = stamp; e.kind = kind; e.exp = exp; e.name = name;
        pos = tq.size();
        while (pos > 0 && tq[pos-1].stamp > stamp) pos--;
        tq.insert(pos, e);
    endfunction

    function automatic void push_b(input bit rd, input logic [31:0] exp, input string name);
        bchk_t e;
        e.rd = rd; e.exp = exp; e.name = name;
        bq.push_back(e);
    endfunction

    // pins for stamps [from,to] while scanning value v with scan origin e
    function automatic void push_scan(input int from, input int to, input logic [15:0] v,
                                      input int e, input string name);
        for (int c = from; c <= to; c++) push_t(c, 0, pins_exp(v, idx_after(c - 1, e)), name);
    endfunction

    task automatic wait_before(input int target);
        if (cyc >= target) late_cnt++;
        while (cyc < target - 1) @(negedge clk);
    endtask

    task automatic bus_at(input int target, input logic w, input logic [1:0] a,
                          input logic [31:0] d, input logic [31:0] exp, input string name);
        wait_before(target);
        ce = 1'b1; we = w; addr = a; wdata = d;
        push_b(!w, exp, name);
        @(posedge clk); #1;
        ce = 1'b0; we = 1'b0;
    endtask

    // Monitor: bus acks and timestamped pin/ack/data checks, plus end-of-run drain check
    always @(negedge clk) begin
        if (ack) begin
            if (bq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: data_o=%h at cyc %0d", rdata, cyc);
            end else begin
                b_cur = bq.pop_front();
                if (b_cur.rd) begin
                    total++;
                    if (rdata !== b_cur.exp) begin
                        bad++;
                        $display("FAIL %s: data_o=%h expected=%h", b_cur.name, rdata, b_cur.exp);
                    end
                end
            end
        end
        while (tq.size() > 0 && tq[0].stamp <= cyc) begin
            t_cur = tq.pop_front();
            total++;
            case (t_cur.kind)
                0:       act = {21'b0, an, seg};
                1:       act = {31'b0, ack};
                default: act = rdata;
            endcase
            if (t_cur.stamp < cyc) begin
                bad++;
                $display("FAIL %s: check at cyc %0d missed (now %0d)", t_cur.name, t_cur.stamp, cyc);
            end else if (act !== t_cur.exp) begin
                bad++;
                $display("FAIL %s@%0d: got=%h expected=%h", t_cur.name, cyc, act, t_cur.exp);
            end
        end
        if (finish_req || cyc > 3000) begin
            if (!finish_req) begin
                total++; bad++;
                $display("FAIL timeout: cyc=%0d expected<=3000", cyc);
            end
            total++;
            if (tq.size() != 0) begin
                bad++; $display("FAIL pin_queue_drain: left=%0d expected=0", tq.size());
            end
            total++;
            if (bq.size() != 0) begin
                bad++; $display("FAIL ack_queue_drain: left=%0d expected=0", bq.size());
            end
            total++;
            if (late_cnt != 0) begin
                bad++; $display("FAIL schedule: late=%0d expected=0", late_cnt);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        int r, base, e0, e1, ev, ex;
        // 1: reset and idle
        r = 3;
        push_t(1, 0, PINS_OFF, "rst_pins");
        push_t(2, 1, 32'd0, "rst_ack");
        push_t(2, 2, 32'd0, "rst_data");
        for (int k = 1; k <= 100; k += 49) begin
            push_t(r + k, 0, PINS_OFF, "idle_pins");
            push_t(r + k, 1, 32'd0, "idle_ack");
            push_t(r + k, 2, 32'd0, "idle_data");
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // register map: VALUE masking, reserved reads 0, STATUS ignores writes
        base = r + 102;
        e0   = base + 8;
        bus_at(base,     1'b1, 2'd0, 32'hDEAD1234, 32'd0, "wr_value");
        bus_at(base + 2, 1'b0, 2'd0, 32'd0, 32'h0000_1234, "rd_value_masked");
        bus_at(base + 4, 1'b0, 2'd3, 32'd0, 32'd0, "rd_reserved");
        bus_at(base + 6, 1'b1, 2'd2, 32'h5, 32'd0, "wr_status");
        push_t(e0, 0, PINS_OFF, "pre_en_pins");

        // 2: enable scan of 1234
        bus_at(e0, 1'b1, 2'd1, 32'h1, 32'd0, "wr_en");
        push_scan(e0 + 1, e0 + 26, 16'h1234, e0, "scan_1234");
        bus_at(e0 + 2,  1'b0, 2'd2, 32'd0, idx_after(e0 + 1, e0),  "status_0");
        bus_at(e0 + 7,  1'b0, 2'd2, 32'd0, idx_after(e0 + 6, e0),  "status_1");
        bus_at(e0 + 12, 1'b0, 2'd2, 32'd0, idx_after(e0 + 11, e0), "status_2");
        bus_at(e0 + 14, 1'b0, 2'd2, 32'd0, idx_after(e0 + 13, e0), "status_3");

        // 3: held read of CTRL, acked every second cycle
        wait_before(e0 + 16);
        ce = 1'b1; we = 1'b0; addr = 2'd1;
        for (int k = 0; k < 6; k++) begin
            push_t(e0 + 16 + k, 1, (k % 2 == 0) ? 32'd1 : 32'd0, "held_ack");
            if (k % 2 == 0) push_b(1'b1, 32'd1, "held_rd_ctrl");
        end
        repeat (6) @(posedge clk);
        #1 ce = 1'b0;

        // 4: VALUE write while digit 2 lit, phase must carry on through wrap
        bus_at(e0 + 26, 1'b1, 2'd0, 32'h0000_ABCD, 32'd0, "wr_abcd");
        push_scan(e0 + 27, e0 + 38, 16'hABCD, e0, "scan_abcd");

        // 5: disable mid-scan, then re-enable
        bus_at(e0 + 40, 1'b1, 2'd1, 32'h0, 32'd0, "wr_dis");
        for (int c = e0 + 41; c <= e0 + 46; c++) push_t(c, 0, PINS_OFF, "dis_pins");
        bus_at(e0 + 44, 1'b0, 2'd2, 32'd0, 32'd0, "status_dis");
        e1 = e0 + 46;
        bus_at(e1, 1'b1, 2'd1, 32'h1, 32'd0, "wr_reen");
        ev = e1 + 10;
        push_scan(e1 + 1, ev, 16'hABCD, e1, "reen_scan");

        // 6: VALUE=5, leading digits blank only with DIGSEG_LZB_EN
        bus_at(ev, 1'b1, 2'd0, 32'h5, 32'd0, "wr_five");
        push_scan(ev + 1, ev + 16, 16'h0005, e1, "scan_five");

        // reset during a write access drops it
        ex = e1 + 30;
        wait_before(ex);
        rst = 1'b1; ce = 1'b1; we = 1'b1; addr = 2'd0; wdata = 32'hFFFF;
        push_t(ex, 0, PINS_OFF, "rst_acc_pins");
        push_t(ex, 1, 32'd0, "rst_acc_ack");
        push_t(ex + 1, 1, 32'd0, "rst_acc_ack2");
        @(posedge clk); #1;
        rst = 1'b0; ce = 1'b0; we = 1'b0;
        bus_at(ex + 3, 1'b0, 2'd0, 32'd0, 32'd0, "rd_value_after_rst");
        bus_at(ex + 5, 1'b0, 2'd1, 32'd0, 32'd0, "rd_ctrl_after_rst");
        bus_at(ex + 7, 1'b0, 2'd2, 32'd0, 32'd0, "rd_status_after_rst");

        wait_before(ex + 10);
        finish_req = 1'b1;
    end

endmodule
